soc_periph_bus_router: RTL and testbench
========================================

// Module: soc_periph_bus_router
// PURPOSE
// - Parametrised N-initiator x M-target router for the req/gnt/rvalid peripheral bus.
// - Successor to the fixed 3x3 AXI node with hard-wired ranges:
//   - initiator/target count and address map are parameters;
//   - adds per-target round-robin arbitration, an unmapped-address error responder and a response timeout.
// - Sits between core/debug/SPI-slave initiators and the memory/peripheral targets.
// PARAMETERS
// - N_INIT      3            number of initiator ports (1..8)
// - N_TGT       3            number of target ports (1..16)
// - AW          32           address width
// - DW          32           data width (multiple of 8)
// - START_ADDR  {N_TGT*AW}   inclusive range starts, target j at [j*AW +: AW]
// - END_ADDR    {N_TGT*AW}   inclusive range ends, same packing
// - TIMEOUT     256          response timeout in cycles; 0 disables the timeout
// PORTS
// - clk          in   1          clock
// - rst_n        in   1          asynchronous active-low reset
// - init_req_i   in   N_INIT     initiator request
// - init_addr_i  in   N_INIT*AW  initiator address
// - init_we_i    in   N_INIT     1 = write
// - init_be_i    in   N_INIT*DW/8  byte enables
// - init_wdata_i in   N_INIT*DW  write data
// - init_gnt_o   out  N_INIT     request accepted this cycle
// - init_rvalid_o out N_INIT     response valid (one pulse per granted request)
// - init_rdata_o out  N_INIT*DW  read data, valid with rvalid
// - init_err_o   out  N_INIT     error response, valid with rvalid
// - tgt_req_o    out  N_TGT      target request
// - tgt_addr_o   out  N_TGT*AW   forwarded address
// - tgt_we_o     out  N_TGT      forwarded write enable
// - tgt_be_o     out  N_TGT*DW/8 forwarded byte enables
// - tgt_wdata_o  out  N_TGT*DW   forwarded write data
// - tgt_gnt_i    in   N_TGT      target accepts request
// - tgt_rvalid_i in   N_TGT      target response valid
// - tgt_rdata_i  in   N_TGT*DW   target read data
// BEHAVIOUR
// - Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
// - Reset state:
//   - all state clears: pending, busy, owner, round-robin pointers = 0, timers = 0;
//   - every output is 0 while in reset.
// - Address decode (combinational):
//   - hit when START <= addr <= END;
//   - if ranges overlap, the lowest target index wins;
//   - an address that hits no target is unmapped.
// - Initiator rule:
//   - one outstanding transaction per initiator;
//   - `pending[i]` sets on `init_gnt_o[i]` and clears on `init_rvalid_o[i]`;
//   - while pending, `init_req_i[i]` is ignored;
//   - a new request is eligible from the cycle after rvalid.
// - Target rule:
//   - one outstanding transaction per target;
//   - a new request is forwarded only when `busy_q[j] == 0`.
// - Arbitration, per target:
//   - round-robin among eligible initiators decoding to target j;
//   - search starts at `ptr[j]`;
//   - `tgt_req_o[j]` and the payload mux follow the winner combinationally;
//   - on `tgt_req_o & tgt_gnt_i`: `init_gnt_o[winner]=1` in the same cycle, `busy_q[j]` sets, `owner_q[j]` = winner, `ptr[j]` = winner+1 (wraps at N_INIT);
//   - `ptr[j]` does not move without a grant.
// - Response path:
//   - `tgt_rvalid_i[j]` with `busy_q[j]` and not stale: `init_rvalid_o[owner]` and `init_rdata_o` pass through in the same cycle, `init_err_o = 0`, `busy_q[j]` clears;
//   - a `tgt_rvalid_i` with `busy_q[j] == 0` is ignored.
// - Unmapped address:
//   - the internal error responder grants in the same cycle;
//   - next cycle it returns rvalid=1, err=1, rdata=`ERR_RDATA`;
//   - it serves one unmapped request per cycle, round-robin, independent of targets.
// - Timeout (TIMEOUT > 0):
//   - `timer[j]` counts cycles while `busy_q[j]` is set and no rvalid has arrived;
//   - at `timer == TIMEOUT`: owner gets rvalid=1, err=1, rdata=`ERR_RDATA`, and `stale[j]` sets;
//   - target j stays busy until its late rvalid, which is swallowed; that rvalid clears busy and stale;
//   - the timer saturates; it never wraps.
// - Simultaneous events:
//   - the same initiator cannot hit two targets (one request per cycle);
//   - a response on target j and a request to target j in the same cycle: the request waits one cycle.
// - Mid-transaction reset: everything drops immediately; late target responses after reset are ignored (busy=0).
// STRUCTURE
// - Package `soc_bus_pkg`: `ERR_RDATA` (32'hBADA_CCE5, truncated/zero-extended to DW), `addr_rule_t` {start,end}, and the `onehot_to_idx` function.
// - One sub-module, `rr_arbiter` (params N, plus `req`, `ptr`, `gnt_onehot`, `gnt_idx`); instantiate it N_TGT+1 times (targets plus error responder).
// TESTING
// - Map 0x0000_0000-0x000F_FFFF / 0x0010_0000-0x001F_FFFF / 0x1A10_0000-0x1A11_FFFF.
//   - Init0 reads 0x0010_0004 -> tgt_req_o[1] same cycle; rvalid returns rdata unchanged to init0, err=0.
// - Inits 0, 1, 2 hold requests to 0x0000_0010 for 6 grants -> grant order 0,1,2,0,1,2; ptr stays put while tgt_gnt_i=0.
// - Init1 accesses 0x2000_0000 -> gnt same cycle, then rvalid=1, err=1, rdata=0xBADACCE5 next cycle; no tgt_req_o.
// - TIMEOUT=8, target 2 never responds:
//   - err rvalid on cycle 8 after grant;
//   - next request to target 2 is blocked;
//   - late rvalid on cycle 20 is swallowed, then the target is usable again.
// - Pending initiator re-asserts req before its rvalid -> no second tgt_req_o; overlap map (0-0xFF to tgt0 and tgt1) -> tgt0 only.
// - Assert rst_n low while targets 0 and 2 are busy -> all outputs 0 asynchronously; tgt_rvalid_i after release produces no init_rvalid_o.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the req/gnt/rvalid peripheral bus router.
//   ERR_RDATA     : read data returned with every error response
//   addr_rule_t   : inclusive address window {start_addr, end_addr}
//   onehot_to_idx : binary index of the set bit in a one-hot vector (up to 16 bits)
package soc_bus_pkg;

  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

  // Address rules are held at a fixed maximum width so the package stays
  // independent of the router's AW parameter.
  localparam int unsigned MAX_AW = 64;

  typedef struct packed {
    logic [MAX_AW-1:0] start_addr;
    logic [MAX_AW-1:0] end_addr;
  } addr_rule_t;

  function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (onehot[k]) idx = 4'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/soc_periph_bus_router_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request vector
//   ptr        : index where the priority search starts
//   gnt_onehot : one-hot winner (all zero when no request)
//   gnt_idx    : binary index of the winner (0 when no request)
module rr_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int unsigned idx;
    idx        = 0;
    gnt_onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if ((gnt_onehot == '0) && req[idx]) gnt_onehot[idx] = 1'b1;
    end
  end

  assign gnt_idx = IW'(onehot_to_idx(16'(gnt_onehot)));

endmodule

// File: rtl/soc_periph_bus_router.sv
// N-initiator x M-target router for the req/gnt/rvalid peripheral bus.
// Per-target round-robin arbitration, an internal error responder for
// unmapped addresses, and an optional per-target response timeout.
//   clk, rst_n                : clock, asynchronous active-low reset
//   init_req_i .. init_wdata_i: initiator request side
//   init_gnt_o .. init_err_o  : initiator grant/response side
//   tgt_req_o .. tgt_wdata_o  : forwarded requests to targets
//   tgt_gnt_i .. tgt_rdata_i  : target grant/response side
module soc_periph_bus_router
  import soc_bus_pkg::*;
#(
  parameter int unsigned N_INIT  = 3,
  parameter int unsigned N_TGT   = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter logic [N_TGT*AW-1:0] START_ADDR = {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [N_TGT*AW-1:0] END_ADDR   = {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF},
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_INIT-1:0]      init_req_i,
  input  logic [N_INIT*AW-1:0]   init_addr_i,
  input  logic [N_INIT-1:0]      init_we_i,
  input  logic [N_INIT*DW/8-1:0] init_be_i,
  input  logic [N_INIT*DW-1:0]   init_wdata_i,
  output logic [N_INIT-1:0]      init_gnt_o,
  output logic [N_INIT-1:0]      init_rvalid_o,
  output logic [N_INIT*DW-1:0]   init_rdata_o,
  output logic [N_INIT-1:0]      init_err_o,
  output logic [N_TGT-1:0]       tgt_req_o,
  output logic [N_TGT*AW-1:0]    tgt_addr_o,
  output logic [N_TGT-1:0]       tgt_we_o,
  output logic [N_TGT*DW/8-1:0]  tgt_be_o,
  output logic [N_TGT*DW-1:0]    tgt_wdata_o,
  input  logic [N_TGT-1:0]       tgt_gnt_i,
  input  logic [N_TGT-1:0]       tgt_rvalid_i,
  input  logic [N_TGT*DW-1:0]    tgt_rdata_i
);

  localparam int unsigned IW = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam int unsigned TW = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned BW = DW / 8;
  localparam logic [DW-1:0] ERR_DW = DW'(ERR_RDATA);

  // Index N_TGT of the arbiter arrays is the error responder.
  logic [N_INIT-1:0] arb_req [N_TGT+1];
  logic [N_INIT-1:0] arb_gnt [N_TGT+1];
  logic [IW-1:0]     arb_idx [N_TGT+1];
  logic [IW-1:0]     ptr_q   [N_TGT+1];

  logic [N_INIT-1:0] pending_q;
  logic [N_TGT-1:0]  busy_q;
  logic [N_TGT-1:0]  stale_q;
  logic [IW-1:0]     owner_q [N_TGT];
  logic [CW-1:0]     timer_q [N_TGT];
  logic              err_rsp_q;
  logic [IW-1:0]     err_idx_q;

  addr_rule_t        rules   [N_TGT];
  logic [N_INIT-1:0] mapped;
  logic [TW-1:0]     tgt_sel [N_INIT];
  logic [N_INIT-1:0] elig;
  logic [N_TGT-1:0]  tgt_fire;
  logic [N_TGT-1:0]  rsp_ok;
  logic [N_TGT-1:0]  late_rsp;
  logic [N_TGT-1:0]  to_fire;
  logic              err_fire;

  function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] idx);
    return (idx == IW'(N_INIT - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned j = 0; j < N_TGT; j++) begin
      rules[j].start_addr = MAX_AW'(START_ADDR[j*AW +: AW]);
      rules[j].end_addr   = MAX_AW'(END_ADDR[j*AW +: AW]);
    end
  end

  // Scan targets from highest to lowest so the lowest matching index wins.
  always_comb begin
    logic [MAX_AW-1:0] a;
    a      = '0;
    mapped = '0;
    for (int unsigned i = 0; i < N_INIT; i++) begin
      tgt_sel[i] = '0;
      a = MAX_AW'(init_addr_i[i*AW +: AW]);
      for (int unsigned j = N_TGT; j > 0; j--) begin
        if ((a >= rules[j-1].start_addr) && (a <= rules[j-1].end_addr)) begin
          mapped[i]  = 1'b1;
          tgt_sel[i] = TW'(j - 1);
        end
      end
    end
  end

  // Gating with rst_n keeps every request-derived output at zero in reset.
  assign elig = init_req_i & ~pending_q & {N_INIT{rst_n}};

  // busy_q also covers the response-cycle case: a request to a target that
  // is returning its response this cycle naturally waits one cycle.
  always_comb begin
    for (int unsigned j = 0; j <= N_TGT; j++) arb_req[j] = '0;
    for (int unsigned i = 0; i < N_INIT; i++) begin
      for (int unsigned j = 0; j < N_TGT; j++) begin
        arb_req[j][i] = elig[i] && mapped[i] && (tgt_sel[i] == TW'(j)) && !busy_q[j];
      end
      arb_req[N_TGT][i] = elig[i] && !mapped[i];
    end
  end

  for (genvar g = 0; g <= N_TGT; g++) begin : g_arb
    rr_arbiter #(.N(N_INIT)) u_arb (
      .req       (arb_req[g]),
      .ptr       (ptr_q[g]),
      .gnt_onehot(arb_gnt[g]),
      .gnt_idx   (arb_idx[g])
    );
  end

  always_comb begin
    int unsigned w;
    w           = 0;
    tgt_req_o   = '0;
    tgt_addr_o  = '0;
    tgt_we_o    = '0;
    tgt_be_o    = '0;
    tgt_wdata_o = '0;
    for (int unsigned j = 0; j < N_TGT; j++) begin
      if (arb_gnt[j] != '0) begin
        w = 32'(arb_idx[j]);
        tgt_req_o[j]             = 1'b1;
        tgt_addr_o[j*AW +: AW]   = init_addr_i[w*AW +: AW];
        tgt_we_o[j]              = init_we_i[w];
        tgt_be_o[j*BW +: BW]     = init_be_i[w*BW +: BW];
        tgt_wdata_o[j*DW +: DW]  = init_wdata_i[w*DW +: DW];
      end
    end
  end

  assign tgt_fire = tgt_req_o & tgt_gnt_i;
  assign err_fire = (arb_gnt[N_TGT] != '0);

  always_comb begin
    init_gnt_o = arb_gnt[N_TGT];
    for (int unsigned j = 0; j < N_TGT; j++) begin
      if (tgt_fire[j]) init_gnt_o = init_gnt_o | arb_gnt[j];
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < N_TGT; j++) begin
      rsp_ok[j]   = tgt_rvalid_i[j] && busy_q[j] && !stale_q[j];
      late_rsp[j] = tgt_rvalid_i[j] && busy_q[j] && stale_q[j];
      to_fire[j]  = (TIMEOUT != 0) && busy_q[j] && !stale_q[j] && !tgt_rvalid_i[j] &&
                    (timer_q[j] == CW'(TIMEOUT));
    end
  end

  // Each initiator has at most one transaction in flight, so at most one
  // source below can address a given initiator in any cycle.
  always_comb begin
    int unsigned w;
    w             = 0;
    init_rvalid_o = '0;
    init_err_o    = '0;
    init_rdata_o  = '0;
    for (int unsigned j = 0; j < N_TGT; j++) begin
      w = 32'(owner_q[j]);
      if (rsp_ok[j]) begin
        init_rvalid_o[w]          = 1'b1;
        init_rdata_o[w*DW +: DW]  = tgt_rdata_i[j*DW +: DW];
      end else if (to_fire[j]) begin
        init_rvalid_o[w]          = 1'b1;
        init_err_o[w]             = 1'b1;
        init_rdata_o[w*DW +: DW]  = ERR_DW;
      end
    end
    if (err_rsp_q) begin
      w = 32'(err_idx_q);
      init_rvalid_o[w]          = 1'b1;
      init_err_o[w]             = 1'b1;
      init_rdata_o[w*DW +: DW]  = ERR_DW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      busy_q    <= '0;
      stale_q   <= '0;
      err_rsp_q <= 1'b0;
      err_idx_q <= '0;
      for (int unsigned j = 0; j <= N_TGT; j++) ptr_q[j] <= '0;
      for (int unsigned j = 0; j < N_TGT; j++) begin
        owner_q[j] <= '0;
        timer_q[j] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_INIT; i++) begin
        if (init_gnt_o[i])         pending_q[i] <= 1'b1;
        else if (init_rvalid_o[i]) pending_q[i] <= 1'b0;
      end
      // timer_q counts cycles since the grant, so it equals TIMEOUT exactly
      // TIMEOUT cycles later, then holds there until the late response.
      for (int unsigned j = 0; j < N_TGT; j++) begin
        if (tgt_fire[j]) begin
          busy_q[j]  <= 1'b1;
          owner_q[j] <= arb_idx[j];
          ptr_q[j]   <= ptr_next(arb_idx[j]);
          timer_q[j] <= CW'(1);
        end else if (rsp_ok[j] || late_rsp[j]) begin
          busy_q[j]  <= 1'b0;
          stale_q[j] <= 1'b0;
          timer_q[j] <= '0;
        end else if (to_fire[j]) begin
          stale_q[j] <= 1'b1;
        end else if ((TIMEOUT != 0) && busy_q[j] && !stale_q[j] &&
                     (timer_q[j] != CW'(TIMEOUT))) begin
          timer_q[j] <= timer_q[j] + 1'b1;
        end
      end
      err_rsp_q <= err_fire;
      err_idx_q <= arb_idx[N_TGT];
      if (err_fire) ptr_q[N_TGT] <= ptr_next(arb_idx[N_TGT]);
    end
  end

endmodule

// File: tb/tb_soc_periph_bus_router.sv
module tb_soc_periph_bus_router;

  logic clk;
  logic rst_n;

  logic [2:0]  init_req, init_we, init_gnt, init_rvalid, init_err;
  logic [95:0] init_addr, init_wdata, init_rdata;
  logic [11:0] init_be;
  logic [2:0]  tgt_req, tgt_we, tgt_gnt, tgt_rvalid;
  logic [95:0] tgt_addr, tgt_wdata, tgt_rdata;
  logic [11:0] tgt_be;

  logic [0:0]  o_init_req, o_init_we, o_init_gnt, o_init_rvalid, o_init_err;
  logic [31:0] o_init_addr, o_init_wdata, o_init_rdata;
  logic [3:0]  o_init_be;
  logic [1:0]  o_tgt_req, o_tgt_we, o_tgt_gnt, o_tgt_rvalid;
  logic [63:0] o_tgt_addr, o_tgt_wdata, o_tgt_rdata;
  logic [7:0]  o_tgt_be;

  int unsigned n_vec;
  int unsigned n_bad;

  soc_periph_bus_router #(
    .N_INIT(3), .N_TGT(3), .AW(32), .DW(32),
    .START_ADDR({32'h1A10_0000, 32'h0010_0000, 32'h0000_0000}),
    .END_ADDR  ({32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF}),
    .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .init_req_i(init_req), .init_addr_i(init_addr), .init_we_i(init_we),
    .init_be_i(init_be), .init_wdata_i(init_wdata),
    .init_gnt_o(init_gnt), .init_rvalid_o(init_rvalid), .init_rdata_o(init_rdata),
    .init_err_o(init_err),
    .tgt_req_o(tgt_req), .tgt_addr_o(tgt_addr), .tgt_we_o(tgt_we), .tgt_be_o(tgt_be),
    .tgt_wdata_o(tgt_wdata), .tgt_gnt_i(tgt_gnt), .tgt_rvalid_i(tgt_rvalid),
    .tgt_rdata_i(tgt_rdata)
  );

  soc_periph_bus_router #(
    .N_INIT(1), .N_TGT(2), .AW(32), .DW(32),
    .START_ADDR({32'h0000_0000, 32'h0000_0000}),
    .END_ADDR  ({32'h0000_00FF, 32'h0000_00FF}),
    .TIMEOUT(0)
  ) dut_ov (
    .clk(clk), .rst_n(rst_n),
    .init_req_i(o_init_req), .init_addr_i(o_init_addr), .init_we_i(o_init_we),
    .init_be_i(o_init_be), .init_wdata_i(o_init_wdata),
    .init_gnt_o(o_init_gnt), .init_rvalid_o(o_init_rvalid), .init_rdata_o(o_init_rdata),
    .init_err_o(o_init_err),
    .tgt_req_o(o_tgt_req), .tgt_addr_o(o_tgt_addr), .tgt_we_o(o_tgt_we), .tgt_be_o(o_tgt_be),
    .tgt_wdata_o(o_tgt_wdata), .tgt_gnt_i(o_tgt_gnt), .tgt_rvalid_i(o_tgt_rvalid),
    .tgt_rdata_i(o_tgt_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    init_req = '0; init_we = '0; init_addr = '0; init_be = '0; init_wdata = '0;
    tgt_gnt = '0; tgt_rvalid = '0; tgt_rdata = '0;
    o_init_req = '0; o_init_we = '0; o_init_addr = '0; o_init_be = '0; o_init_wdata = '0;
    o_tgt_gnt = '0; o_tgt_rvalid = '0; o_tgt_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    init_req = 3'b001; init_addr[31:0] = 32'h0000_0010; o_init_req = 1'b1;
    #1;
    n_vec++; if (tgt_req !== 3'b000) begin n_bad++; $display("FAIL rst_tgt_req got=%h exp=%h", tgt_req, 3'b000); end
    n_vec++; if ({init_gnt, init_rvalid, init_err} !== 9'h0) begin n_bad++; $display("FAIL rst_init_ctl got=%h exp=%h", {init_gnt, init_rvalid, init_err}, 9'h0); end
    n_vec++; if ({init_rdata, tgt_addr} !== 192'h0) begin n_bad++; $display("FAIL rst_data got=%h exp=0", {init_rdata, tgt_addr}); end
    n_vec++; if ({o_tgt_req, o_init_gnt} !== 3'b000) begin n_bad++; $display("FAIL rst_ov got=%h exp=%h", {o_tgt_req, o_init_gnt}, 3'b000); end
    @(negedge clk); idle(); rst_n = 1'b1;
  endtask

  task automatic test_decode_read();
    @(negedge clk); idle();
    init_req = 3'b001; init_addr[31:0] = 32'h0010_0004; init_be[3:0] = 4'hF; tgt_gnt = 3'b010;
    #1;
    n_vec++; if (tgt_req !== 3'b010) begin n_bad++; $display("FAIL dec_tgt_req got=%h exp=%h", tgt_req, 3'b010); end
    n_vec++; if (tgt_addr[63:32] !== 32'h0010_0004) begin n_bad++; $display("FAIL dec_tgt_addr got=%h exp=%h", tgt_addr[63:32], 32'h0010_0004); end
    n_vec++; if (tgt_be[7:4] !== 4'hF) begin n_bad++; $display("FAIL dec_tgt_be got=%h exp=%h", tgt_be[7:4], 4'hF); end
    n_vec++; if (init_gnt !== 3'b001) begin n_bad++; $display("FAIL dec_gnt got=%h exp=%h", init_gnt, 3'b001); end
    @(negedge clk); idle();
    tgt_rvalid = 3'b010; tgt_rdata[63:32] = 32'hCAFE_F00D;
    #1;
    n_vec++; if (init_rvalid !== 3'b001) begin n_bad++; $display("FAIL dec_rvalid got=%h exp=%h", init_rvalid, 3'b001); end
    n_vec++; if (init_rdata[31:0] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL dec_rdata got=%h exp=%h", init_rdata[31:0], 32'hCAFE_F00D); end
    n_vec++; if (init_err !== 3'b000) begin n_bad++; $display("FAIL dec_err got=%h exp=%h", init_err, 3'b000); end
    @(negedge clk); idle(); #1;
    n_vec++; if (init_rvalid !== 3'b000) begin n_bad++; $display("FAIL dec_rvalid_once got=%h exp=%h", init_rvalid, 3'b000); end
  endtask

  task automatic test_round_robin();
    int unsigned exp;
    logic [2:0] exp_oh;
    exp = 0;
    @(negedge clk); idle();
    init_req = 3'b111; init_we = 3'b111;
    init_addr = {32'h0000_0010, 32'h0000_0010, 32'h0000_0010};
    init_wdata = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001};
    for (int g = 0; g < 6; g++) begin
      exp_oh = 3'b001 << exp;
      if (g != 0) @(negedge clk);
      tgt_gnt = 3'b000; tgt_rvalid = 3'b000;
      #1;
      n_vec++; if (tgt_req !== 3'b001 || tgt_wdata[31:0] !== 32'h2222_0001 + exp) begin n_bad++; $display("FAIL rr_stall_%0d got=%h/%h exp=001/%h", g, tgt_req, tgt_wdata[31:0], 32'h2222_0001 + exp); end
      n_vec++; if (init_gnt !== 3'b000) begin n_bad++; $display("FAIL rr_nogrant_%0d got=%h exp=%h", g, init_gnt, 3'b000); end
      @(negedge clk); tgt_gnt = 3'b001; #1;
      n_vec++; if (init_gnt !== exp_oh || tgt_wdata[31:0] !== 32'h2222_0001 + exp) begin n_bad++; $display("FAIL rr_grant_%0d got=%h/%h exp=%h/%h", g, init_gnt, tgt_wdata[31:0], exp_oh, 32'h2222_0001 + exp); end
      @(negedge clk); tgt_gnt = 3'b000; tgt_rvalid = 3'b001; #1;
      n_vec++; if (init_rvalid !== exp_oh || tgt_req !== 3'b000) begin n_bad++; $display("FAIL rr_rsp_%0d got=%h/%h exp=%h/000", g, init_rvalid, tgt_req, exp_oh); end
      exp = (exp + 1) % 3;
    end
    @(negedge clk); idle();
  endtask

  task automatic test_unmapped();
    @(negedge clk); idle();
    init_req = 3'b010; init_addr[63:32] = 32'h2000_0000;
    #1;
    n_vec++; if (init_gnt !== 3'b010) begin n_bad++; $display("FAIL um_gnt got=%h exp=%h", init_gnt, 3'b010); end
    n_vec++; if (tgt_req !== 3'b000 || init_rvalid !== 3'b000) begin n_bad++; $display("FAIL um_quiet got=%h/%h exp=0/0", tgt_req, init_rvalid); end
    @(negedge clk); idle(); #1;
    n_vec++; if (init_rvalid !== 3'b010 || init_err !== 3'b010) begin n_bad++; $display("FAIL um_rsp got=%h/%h exp=010/010", init_rvalid, init_err); end
    n_vec++; if (init_rdata[63:32] !== 32'hBADA_CCE5) begin n_bad++; $display("FAIL um_rdata got=%h exp=%h", init_rdata[63:32], 32'hBADA_CCE5); end
    @(negedge clk); #1;
    n_vec++; if (init_rvalid !== 3'b000) begin n_bad++; $display("FAIL um_once got=%h exp=%h", init_rvalid, 3'b000); end
  endtask

  task automatic test_timeout();
    @(negedge clk); idle();
    init_req = 3'b100; init_addr[95:64] = 32'h1A10_0000; tgt_gnt = 3'b100;
    #1;
    n_vec++; if (init_gnt !== 3'b100) begin n_bad++; $display("FAIL to_gnt got=%h exp=%h", init_gnt, 3'b100); end
    for (int c = 1; c < 20; c++) begin
      @(negedge clk); idle();
      if (c >= 9) begin init_req = 3'b001; init_addr[31:0] = 32'h1A10_0004; tgt_gnt = 3'b100; end
      #1;
      if (c == 8) begin
        n_vec++; if (init_rvalid !== 3'b100 || init_err !== 3'b100) begin n_bad++; $display("FAIL to_fire got=%h/%h exp=100/100", init_rvalid, init_err); end
        n_vec++; if (init_rdata[95:64] !== 32'hBADA_CCE5) begin n_bad++; $display("FAIL to_rdata got=%h exp=%h", init_rdata[95:64], 32'hBADA_CCE5); end
      end else begin
        n_vec++; if (init_rvalid !== 3'b000) begin n_bad++; $display("FAIL to_quiet_%0d got=%h exp=%h", c, init_rvalid, 3'b000); end
      end
      if (c >= 9) begin
        n_vec++; if (tgt_req !== 3'b000 || init_gnt !== 3'b000) begin n_bad++; $display("FAIL to_blocked_%0d got=%h/%h exp=0/0", c, tgt_req, init_gnt); end
      end
    end
    @(negedge clk);
    tgt_gnt = 3'b000; tgt_rvalid = 3'b100; tgt_rdata[95:64] = 32'h1234_5678;
    #1;
    n_vec++; if (init_rvalid !== 3'b000 || tgt_req !== 3'b000) begin n_bad++; $display("FAIL to_swallow got=%h/%h exp=0/0", init_rvalid, tgt_req); end
    @(negedge clk); tgt_rvalid = 3'b000; tgt_gnt = 3'b100; #1;
    n_vec++; if (tgt_req !== 3'b100 || init_gnt !== 3'b001 || tgt_addr[95:64] !== 32'h1A10_0004) begin n_bad++; $display("FAIL to_reuse got=%h/%h/%h exp=100/001/1a100004", tgt_req, init_gnt, tgt_addr[95:64]); end
    @(negedge clk); idle(); tgt_rvalid = 3'b100; tgt_rdata[95:64] = 32'h0000_AAAA; #1;
    n_vec++; if (init_rvalid !== 3'b001 || init_err !== 3'b000 || init_rdata[31:0] !== 32'h0000_AAAA) begin n_bad++; $display("FAIL to_reuse_rsp got=%h/%h/%h exp=001/000/0000aaaa", init_rvalid, init_err, init_rdata[31:0]); end
    @(negedge clk); idle();
  endtask

  task automatic test_pending();
    @(negedge clk); idle();
    init_req = 3'b001; init_addr[31:0] = 32'h0000_0010; tgt_gnt = 3'b001;
    #1;
    n_vec++; if (init_gnt !== 3'b001) begin n_bad++; $display("FAIL pend_gnt got=%h exp=%h", init_gnt, 3'b001); end
    @(negedge clk); #1;
    n_vec++; if (tgt_req !== 3'b000 || init_gnt !== 3'b000) begin n_bad++; $display("FAIL pend_block got=%h/%h exp=0/0", tgt_req, init_gnt); end
    @(negedge clk); tgt_rvalid = 3'b001; #1;
    n_vec++; if (init_rvalid !== 3'b001 || tgt_req !== 3'b000) begin n_bad++; $display("FAIL pend_rsp got=%h/%h exp=001/000", init_rvalid, tgt_req); end
    @(negedge clk); tgt_rvalid = 3'b000; #1;
    n_vec++; if (tgt_req !== 3'b001 || init_gnt !== 3'b001) begin n_bad++; $display("FAIL pend_reissue got=%h/%h exp=001/001", tgt_req, init_gnt); end
    @(negedge clk); idle(); tgt_rvalid = 3'b001; #1;
    n_vec++; if (init_rvalid !== 3'b001) begin n_bad++; $display("FAIL pend_rsp2 got=%h exp=%h", init_rvalid, 3'b001); end
    @(negedge clk); idle();
  endtask

  task automatic test_overlap();
    @(negedge clk); idle();
    o_init_req = 1'b1; o_init_addr = 32'h0000_0080; o_tgt_gnt = 2'b11;
    #1;
    n_vec++; if (o_tgt_req !== 2'b01 || o_init_gnt !== 1'b1) begin n_bad++; $display("FAIL ov_tgt0 got=%h/%h exp=01/1", o_tgt_req, o_init_gnt); end
    @(negedge clk); idle(); o_tgt_rvalid = 2'b01; o_tgt_rdata[31:0] = 32'h0000_0F0F; #1;
    n_vec++; if (o_init_rvalid !== 1'b1 || o_init_rdata !== 32'h0000_0F0F) begin n_bad++; $display("FAIL ov_rsp got=%h/%h exp=1/00000f0f", o_init_rvalid, o_init_rdata); end
    @(negedge clk); idle(); o_init_req = 1'b1; o_init_addr = 32'h0000_0100; #1;
    n_vec++; if (o_tgt_req !== 2'b00 || o_init_gnt !== 1'b1) begin n_bad++; $display("FAIL ov_unmapped got=%h/%h exp=00/1", o_tgt_req, o_init_gnt); end
    @(negedge clk); idle(); #1;
    n_vec++; if (o_init_err !== 1'b1 || o_init_rdata !== 32'hBADA_CCE5) begin n_bad++; $display("FAIL ov_err got=%h/%h exp=1/badacce5", o_init_err, o_init_rdata); end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle();
    init_req = 3'b011; init_addr[31:0] = 32'h0000_0010; init_addr[63:32] = 32'h1A10_0000;
    tgt_gnt = 3'b101;
    #1;
    n_vec++; if (init_gnt !== 3'b011 || tgt_req !== 3'b101) begin n_bad++; $display("FAIL mr_busy got=%h/%h exp=011/101", init_gnt, tgt_req); end
    @(negedge clk); idle(); init_req = 3'b100; init_addr[95:64] = 32'h0000_0010; #1;
    n_vec++; if (tgt_req !== 3'b000) begin n_bad++; $display("FAIL mr_blocked got=%h exp=%h", tgt_req, 3'b000); end
    #2; rst_n = 1'b0; #1;
    n_vec++; if ({tgt_req, init_gnt, init_rvalid, init_err} !== 12'h0 || {tgt_addr, init_rdata} !== 192'h0) begin n_bad++; $display("FAIL mr_async got=%h exp=0", {tgt_req, init_gnt, init_rvalid, init_err}); end
    @(negedge clk); idle(); rst_n = 1'b1; tgt_rvalid = 3'b101; #1;
    n_vec++; if (init_rvalid !== 3'b000) begin n_bad++; $display("FAIL mr_late got=%h exp=%h", init_rvalid, 3'b000); end
    @(negedge clk); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_decode_read();
    test_round_robin();
    test_unmapped();
    test_timeout();
    test_pending();
    test_overlap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
